// File: rtl/byte_stream_packetizer.sv
// Byte-stream decoder: strips SOP/EOP/channel markers and escapes, emitting framed payload beats.
// Define BYTE_STREAM_PACKETIZER_CHANNEL_EN to decode channel numbers; otherwise out_channel is 0.
module byte_stream_packetizer (
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] out_channel,
  output logic       out_startofpacket,
  output logic       out_endofpacket
);
  localparam logic [7:0] SOP_B = 8'h7A;
  localparam logic [7:0] EOP_B = 8'h7B;
  localparam logic [7:0] CHN_B = 8'h7C;
  localparam logic [7:0] ESC_B = 8'h7D;
  localparam logic [7:0] ESC_X = 8'h20;

  typedef enum logic [1:0] {NORMAL, ESCAPE, CHANNEL, CHANNEL_ESC} state_t;

  state_t     state;
  logic       sop_pend, eop_pend;
  logic       accept, emit;
  logic [7:0] emit_byte;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    emit      = 1'b0;
    emit_byte = in_data;
    case (state)
      NORMAL:  emit = accept && (in_data < SOP_B || in_data > ESC_B);
      ESCAPE: begin
        emit      = accept;
        emit_byte = in_data ^ ESC_X;
      end
      default: emit = 1'b0;
    endcase
  end

`ifdef BYTE_STREAM_PACKETIZER_CHANNEL_EN
  // chan_q tracks the latest decoded channel; out_ch_q only moves with an emitted beat
  logic [7:0] chan_q, out_ch_q;
  assign out_channel = out_ch_q;
`else
  assign out_channel = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= NORMAL;
      sop_pend          <= 1'b0;
      eop_pend          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
`ifdef BYTE_STREAM_PACKETIZER_CHANNEL_EN
      chan_q            <= 8'h00;
      out_ch_q          <= 8'h00;
`endif
    end else begin
      if (accept) begin
        case (state)
          NORMAL: begin
            case (in_data)
              SOP_B:   sop_pend <= 1'b1;
              EOP_B:   eop_pend <= 1'b1;
              CHN_B:   state    <= CHANNEL;
              ESC_B:   state    <= ESCAPE;
              default: ;
            endcase
          end
          ESCAPE: state <= NORMAL;
          CHANNEL: begin
            if (in_data == ESC_B) state <= CHANNEL_ESC;
            else begin
              state <= NORMAL;
`ifdef BYTE_STREAM_PACKETIZER_CHANNEL_EN
              chan_q <= in_data;
`endif
            end
          end
          CHANNEL_ESC: begin
            state <= NORMAL;
`ifdef BYTE_STREAM_PACKETIZER_CHANNEL_EN
            chan_q <= in_data ^ ESC_X;
`endif
          end
          default: state <= NORMAL;
        endcase
      end
      if (emit) begin
        out_valid         <= 1'b1;
        out_data          <= emit_byte;
        out_startofpacket <= sop_pend;
        out_endofpacket   <= eop_pend;
        sop_pend          <= 1'b0;
        eop_pend          <= 1'b0;
`ifdef BYTE_STREAM_PACKETIZER_CHANNEL_EN
        out_ch_q          <= chan_q;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_byte_stream_packetizer.sv
// Scoreboard bench: a stream parser predicts beats; a negedge monitor checks beats, latency and stalls.
module tb_byte_stream_packetizer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_ready;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_channel;
  logic       out_startofpacket, out_endofpacket;

  byte_stream_packetizer dut (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket));

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef bit eq_t[$];
  typedef struct packed {logic [7:0] d; logic sop; logic eop; logic [7:0] ch;} beat_t;

  beat_t      exp_q[$];
  int         n_checks = 0, n_pass = 0;
  int         rdy_mode = 0;
  bit         gaps = 1'b0;
  bit         cur_emit = 1'b0;
  logic       m_sop = 1'b0, m_eop = 1'b0;
  logic [7:0] m_chan = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  task automatic push_beat(input logic [7:0] d);
    exp_q.push_back('{d: d, sop: m_sop, eop: m_eop, ch: m_chan});
    m_sop = 1'b0;
    m_eop = 1'b0;
  endtask

  task automatic set_chan(input logic [7:0] c);
`ifdef BYTE_STREAM_PACKETIZER_CHANNEL_EN
    m_chan = c;
`else
    m_chan = 8'h00 & c;
`endif
  endtask

  // Reference: walk the byte list as a framed stream and list the beats it must yield
  task automatic parse(input bq_t b, output eq_t em);
    int i;
    em = {};
    foreach (b[k]) em.push_back(1'b0);
    i = 0;
    while (i < b.size()) begin
      case (b[i])
        8'h7A: begin m_sop = 1'b1; i += 1; end
        8'h7B: begin m_eop = 1'b1; i += 1; end
        8'h7C: begin
          if (i + 1 < b.size() && b[i+1] == 8'h7D) begin
            if (i + 2 < b.size()) set_chan(b[i+2] ^ 8'h20);
            i += 3;
          end else begin
            if (i + 1 < b.size()) set_chan(b[i+1]);
            i += 2;
          end
        end
        8'h7D: begin
          if (i + 1 < b.size()) begin
            push_beat(b[i+1] ^ 8'h20);
            em[i+1] = 1'b1;
          end
          i += 2;
        end
        default: begin push_beat(b[i]); em[i] = 1'b1; i += 1; end
      endcase
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1
  task automatic send_bytes(input bq_t b);
    eq_t em;
    bit  acc;
    int  guard;
    parse(b, em);
    foreach (b[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        cur_emit = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b[i];
      cur_emit = em[i];
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 500) begin
          chk("accept_timeout", 32'd0, 32'd1);
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    cur_emit = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_channel", out_channel, 8'h00);
    chk("rst_sop", out_startofpacket, 1'b0);
    chk("rst_eop", out_endofpacket, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  function automatic logic [7:0] plain_byte();
    logic [7:0] r = 8'($urandom);
    if (r >= 8'h7A && r <= 8'h7D) r = r ^ 8'h80;
    return r;
  endfunction

  task automatic gen_segment(output bq_t b);
    int n = $urandom_range(3, 12);
    logic [7:0] r;
    b = {};
    repeat (n) begin
      case ($urandom_range(0, 9))
        0: b.push_back(8'h7A);
        1: b.push_back(8'h7B);
        2: begin
          r = 8'($urandom);
          if (r == 8'h7D) r = 8'h7C;
          b.push_back(8'h7C); b.push_back(r);
        end
        3: begin b.push_back(8'h7C); b.push_back(8'h7D); b.push_back(8'($urandom)); end
        4, 5: begin b.push_back(8'h7D); b.push_back(8'($urandom)); end
        default: b.push_back(plain_byte());
      endcase
    end
    b.push_back(plain_byte());
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor
  bit    lat_pend = 1'b0, held = 1'b0;
  beat_t snap, got, want;
  always @(negedge clk) begin
    if (!reset_n) begin
      lat_pend = 1'b0;
      held = 1'b0;
    end else begin
      got = '{d: out_data, sop: out_startofpacket, eop: out_endofpacket, ch: out_channel};
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", got, snap);
      end
      if (lat_pend) chk("latency_valid", out_valid, 1'b1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {24'h0, out_data}, 32'hFFFF);
        else begin
          want = exp_q.pop_front();
          chk("beat_data", got.d, want.d);
          chk("beat_sop", got.sop, want.sop);
          chk("beat_eop", got.eop, want.eop);
          chk("beat_channel", got.ch, want.ch);
        end
      end
      held = out_valid && !out_ready;
      snap = got;
      lat_pend = in_valid && in_ready && cur_emit;
    end
  end

  initial begin
    bq_t seg;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    send_bytes('{8'h7A, 8'h11, 8'h22, 8'h7B, 8'h33});
    wait_drain();
    send_bytes('{8'h7A, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5D});
    wait_drain();
    send_bytes('{8'h7A, 8'h7B, 8'h44});
    send_bytes('{8'h7A, 8'h7A, 8'h55});
    wait_drain();
    send_bytes('{8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'h01, 8'h7B, 8'h02});
    wait_drain();

    // Downstream stall: first byte sits on the output while the second waits
    rdy_mode = 2;
    @(posedge clk); #1;
    fork
      send_bytes('{8'h21, 8'h22});
      begin
        repeat (3) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_out_valid", out_valid, 1'b1);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();

    // Reset in the middle of an escape sequence
    send_bytes('{8'h7A, 8'h7D});
    #2;
    reset_n = 1'b0;
    m_sop = 1'b0; m_eop = 1'b0; m_chan = 8'h00;
    @(negedge clk);
    check_reset_outputs();
    chk("rst_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_bytes('{8'h5D});
    wait_drain();

    gaps = 1'b1;
    rdy_mode = 1;
    repeat (40) begin
      gen_segment(seg);
      send_bytes(seg);
    end
    rdy_mode = 0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
